// File: rtl/meas_sequencer.sv
// Masked multi-channel ADC sequencer: oversamples each enabled channel 2^AVG_LOG2 times,
// publishes the truncated mean per channel and guards every conversion with a watchdog.
module meas_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int DATA_W         = 16,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [NUM_CH-1:0]        ch_mask_i,
  input  logic [DATA_W-1:0]        adc_data_i,
  input  logic                     adc_drdy_i,
  output logic [CH_W-1:0]          adc_channel_o,
  output logic                     adc_start_o,
  output logic [NUM_CH*DATA_W-1:0] meas_flat_o,
  output logic [NUM_CH-1:0]        meas_valid_o,
  output logic                     frame_done_o,
  output logic                     timeout_o,
  output logic                     busy_o
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CH_W-1:0]   r_ch;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [WD_W-1:0]   r_wdog;
  logic [DATA_W-1:0] r_meas [NUM_CH];
  logic [NUM_CH-1:0] r_valid;
  logic              r_frame_done;

  logic [CH_W-1:0]   w_first;
  logic [CH_W-1:0]   w_above;
  logic              w_above_found;
  logic              w_any;
  logic [CH_W-1:0]   w_next_ch;
  logic              w_wrap;
  logic              w_drdy;
  logic              w_last;
  logic              w_tmo;
  logic              w_go_on;
  logic [ACC_W-1:0]  w_acc_sum;

  // Lowest set mask bit overall, and lowest set bit strictly above the current channel.
  always_comb begin
    w_first       = '0;
    w_above       = '0;
    w_above_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask_i[i]) begin
        w_first = CH_W'(i);
        if (i > int'(r_ch)) begin
          w_above       = CH_W'(i);
          w_above_found = 1'b1;
        end
      end
    end
  end

  assign w_any     = |ch_mask_i;
  assign w_next_ch = w_above_found ? w_above : w_first;
  assign w_wrap    = w_any && !w_above_found;
  assign w_drdy    = (r_state == S_WAIT) && adc_drdy_i;
  assign w_last    = (r_cnt == CNT_W'(AVG_N - 1));
  assign w_tmo     = (r_state == S_WAIT) && !adc_drdy_i && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_go_on   = enable_i && w_any;
  assign w_acc_sum = r_acc + ACC_W'(adc_data_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (enable_i && w_any) w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        // A channel in progress always finishes its averaging run, even with enable low.
        if (w_drdy) w_state_next = (!w_last || w_go_on) ? S_START : S_IDLE;
        else if (w_tmo) w_state_next = w_go_on ? S_START : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    adc_start_o  = (r_state == S_START);
    busy_o       = (r_state != S_IDLE);
    timeout_o    = w_tmo;
    frame_done_o = r_frame_done | (w_tmo & w_wrap);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ch         <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_wdog       <= '0;
      r_valid      <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_meas[i] <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE:  if (enable_i && w_any) r_ch <= w_first;
        S_START: r_wdog <= '0;
        S_WAIT: begin
          r_wdog <= r_wdog + WD_W'(1);
          if (w_drdy) begin
            if (w_last) begin
              r_meas[r_ch]  <= w_acc_sum[AVG_LOG2 +: DATA_W];
              r_valid[r_ch] <= 1'b1;
              r_acc         <= '0;
              r_cnt         <= '0;
              r_ch          <= w_next_ch;
              r_frame_done  <= w_wrap;
            end else begin
              r_acc <= w_acc_sum;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (w_tmo) begin
            // Old result of a channel that stopped answering is stale.
            r_valid[r_ch] <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_ch          <= w_next_ch;
          end
        end
        default: ;
      endcase
    end
  end

  assign adc_channel_o = r_ch;
  assign meas_valid_o  = r_valid;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_flat
    assign meas_flat_o[gi*DATA_W +: DATA_W] = r_meas[gi];
  end

endmodule
